// File: rtl/cpu_fmt_pkg.sv
// -----------------------------------------------------------------------------
// cpu_fmt_pkg
// Shared definitions for the CPU trace-line formatter:
//   - fmt_state_e : 4-bit state encoding (IDLE plus the 14 character states)
//   - ASCII_*     : fixed punctuation characters of a trace line
//   - KIND_REG / KIND_MEM : request kind encoding
//   - hex_char()  : nibble to lowercase ASCII hex digit
// -----------------------------------------------------------------------------
package cpu_fmt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CARET = 4'd1,
        ST_TIME  = 4'd2,
        ST_AT    = 4'd3,
        ST_PC    = 4'd4,
        ST_COLON = 4'd5,
        ST_SP1   = 4'd6,
        ST_SIGIL = 4'd7,
        ST_IDX   = 4'd8,
        ST_SP2   = 4'd9,
        ST_LT    = 4'd10,
        ST_EQ    = 4'd11,
        ST_SP3   = 4'd12,
        ST_DATA  = 4'd13,
        ST_HASH  = 4'd14
    } fmt_state_e;

    localparam logic [7:0] ASCII_CARET  = 8'h5e;  // '^'
    localparam logic [7:0] ASCII_AT     = 8'h40;  // '@'
    localparam logic [7:0] ASCII_COLON  = 8'h3a;  // ':'
    localparam logic [7:0] ASCII_SPACE  = 8'h20;  // ' '
    localparam logic [7:0] ASCII_DOLLAR = 8'h24;  // '$'
    localparam logic [7:0] ASCII_STAR   = 8'h2a;  // '*'
    localparam logic [7:0] ASCII_LT     = 8'h3c;  // '<'
    localparam logic [7:0] ASCII_EQ     = 8'h3d;  // '='
    localparam logic [7:0] ASCII_HASH   = 8'h23;  // '#'
    localparam logic [7:0] ASCII_ZERO   = 8'h30;  // '0'

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // 0-9 -> '0'-'9', 10-15 -> 'a'-'f' ('a' - 10 = 8'h57)
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end
        return 8'h57 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/cpu_fmt_digit_sel.sv
// -----------------------------------------------------------------------------
// cpu_fmt_digit_sel
// Purely combinational character selector. Given a state, a digit counter and
// the latched request fields, returns the ASCII character for that position.
// Ports:
//   state_i     : formatter state whose character is wanted
//   cnt_i       : digit index within the current field (0 = least significant)
//   kind_i      : 0 register write, 1 memory write
//   time_bcd_i  : packed BCD time
//   pc_i, addr_i, data_i : 32-bit values printed as hex
//   reg_num_i   : register number printed as two decimal digits max
//   char_o      : selected ASCII character (8'h00 for IDLE)
// -----------------------------------------------------------------------------
module cpu_fmt_digit_sel
    import cpu_fmt_pkg::*;
#(
    parameter int TIME_DIGITS = 4
) (
    input  fmt_state_e                   state_i,
    input  logic [2:0]                   cnt_i,
    input  logic                         kind_i,
    input  logic [4*TIME_DIGITS-1:0]     time_bcd_i,
    input  logic [31:0]                  pc_i,
    input  logic [4:0]                   reg_num_i,
    input  logic [31:0]                  addr_i,
    input  logic [31:0]                  data_i,
    output logic [7:0]                   char_o
);

    logic [4:0] nib_shift;
    logic [3:0] time_nib;
    logic [3:0] pc_nib;
    logic [3:0] addr_nib;
    logic [3:0] data_nib;
    logic [1:0] tens;
    logic [3:0] units;

    assign nib_shift = {cnt_i, 2'b00};
    assign time_nib  = 4'(time_bcd_i >> nib_shift);
    assign pc_nib    = 4'(pc_i >> nib_shift);
    assign addr_nib  = 4'(addr_i >> nib_shift);
    assign data_nib  = 4'(data_i >> nib_shift);

    // Decimal split by range compare; reg_num never exceeds 31.
    always_comb begin
        tens  = 2'd0;
        units = reg_num_i[3:0];
        if (reg_num_i >= 5'd30) begin
            tens  = 2'd3;
            units = 4'(reg_num_i - 5'd30);
        end else if (reg_num_i >= 5'd20) begin
            tens  = 2'd2;
            units = 4'(reg_num_i - 5'd20);
        end else if (reg_num_i >= 5'd10) begin
            tens  = 2'd1;
            units = 4'(reg_num_i - 5'd10);
        end
    end

    always_comb begin
        char_o = 8'h00;
        case (state_i)
            ST_CARET: char_o = ASCII_CARET;
            ST_TIME:  char_o = hex_char(time_nib);
            ST_AT:    char_o = ASCII_AT;
            ST_PC:    char_o = hex_char(pc_nib);
            ST_COLON: char_o = ASCII_COLON;
            ST_SP1:   char_o = ASCII_SPACE;
            ST_SIGIL: char_o = (kind_i == KIND_MEM) ? ASCII_STAR : ASCII_DOLLAR;
            ST_IDX: begin
                if (kind_i == KIND_MEM) begin
                    char_o = hex_char(addr_nib);
                end else if (cnt_i[0]) begin
                    char_o = ASCII_ZERO + {6'd0, tens};
                end else begin
                    char_o = ASCII_ZERO + {4'd0, units};
                end
            end
            ST_SP2:   char_o = ASCII_SPACE;
            ST_LT:    char_o = ASCII_LT;
            ST_EQ:    char_o = ASCII_EQ;
            ST_SP3:   char_o = ASCII_SPACE;
            ST_DATA:  char_o = hex_char(data_nib);
            ST_HASH:  char_o = ASCII_HASH;
            default:  char_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/cpu_trace_formatter.sv
// -----------------------------------------------------------------------------
// cpu_trace_formatter
// Serialises one CPU write-back event into an ASCII trace line, one character
// per accepted output beat:
//   register: "^<time>@<pc>: $<reg> <= <data>#"
//   memory  : "^<time>@<pc>: *<addr> <= <data>#"
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : event handshake (ready only while idle)
//   req_kind, time_bcd, pc, reg_num, addr, data : event fields, latched on accept
//   out_char/out_valid/out_ready : character stream handshake
//   err                   : one-cycle pulse when a request had a non-BCD time digit
// Build option:
//   CPU_FMT_LEAD_ZERO_TRIM_EN : when defined, leading zeros of time and reg_num
//   are suppressed (at least one digit always printed); otherwise time prints
//   TIME_DIGITS digits and reg_num prints two digits.
// TIME_DIGITS must be 1..4.
// -----------------------------------------------------------------------------
module cpu_trace_formatter
    import cpu_fmt_pkg::*;
#(
    parameter int TIME_DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_kind,
    input  logic [4*TIME_DIGITS-1:0] time_bcd,
    input  logic [31:0]              pc,
    input  logic [4:0]               reg_num,
    input  logic [31:0]              addr,
    input  logic [31:0]              data,
    output logic [7:0]               out_char,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err
);

    fmt_state_e                 state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic                       kind_q;
    logic [4*TIME_DIGITS-1:0]   time_q;
    logic [31:0]                pc_q;
    logic [4:0]                 reg_q;
    logic [31:0]                addr_q;
    logic [31:0]                data_q;
    logic                       req_ready_q, req_ready_d;
    logic                       out_valid_q, out_valid_d;
    logic [7:0]                 out_char_q, out_char_d;
    logic                       err_q, err_d;

    logic                       accept;
    logic                       advance;
    logic                       bcd_bad;
    logic [TIME_DIGITS-1:0]     digit_bad;
    logic [2:0]                 time_start;
    logic [2:0]                 idx_start;
    logic [7:0]                 sel_char;

    assign accept  = req_valid & req_ready_q;
    assign advance = out_valid_q & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < TIME_DIGITS; gi++) begin : g_bcd_chk
            assign digit_bad[gi] = (time_bcd[4*gi +: 4] > 4'd9);
        end
    endgenerate
    assign bcd_bad = |digit_bad;

    // First digit index printed for time and for the register/address field.
`ifdef CPU_FMT_LEAD_ZERO_TRIM_EN
    logic [TIME_DIGITS-1:0] digit_nz;
    generate
        for (gi = 0; gi < TIME_DIGITS; gi++) begin : g_nz
            assign digit_nz[gi] = |time_q[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        time_start = 3'd0;
        for (int i = 0; i < TIME_DIGITS; i++) begin
            if (digit_nz[i]) begin
                time_start = 3'(i);
            end
        end
    end

    assign idx_start = (kind_q == KIND_MEM) ? 3'd7 :
                       (reg_q >= 5'd10)     ? 3'd1 : 3'd0;
`else
    assign time_start = 3'(TIME_DIGITS - 1);
    assign idx_start  = (kind_q == KIND_MEM) ? 3'd7 : 3'd1;
`endif

    // Next-state: one step per accepted beat; digit states count down to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (accept && !bcd_bad) begin
                state_d = ST_CARET;
                cnt_d   = 3'd0;
            end
        end else if (advance) begin
            case (state_q)
                ST_CARET: begin
                    state_d = ST_TIME;
                    cnt_d   = time_start;
                end
                ST_TIME: begin
                    if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                    else               state_d = ST_AT;
                end
                ST_AT: begin
                    state_d = ST_PC;
                    cnt_d   = 3'd7;
                end
                ST_PC: begin
                    if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                    else               state_d = ST_COLON;
                end
                ST_COLON: state_d = ST_SP1;
                ST_SP1:   state_d = ST_SIGIL;
                ST_SIGIL: begin
                    state_d = ST_IDX;
                    cnt_d   = idx_start;
                end
                ST_IDX: begin
                    if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                    else               state_d = ST_SP2;
                end
                ST_SP2:   state_d = ST_LT;
                ST_LT:    state_d = ST_EQ;
                ST_EQ:    state_d = ST_SP3;
                ST_SP3: begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd7;
                end
                ST_DATA: begin
                    if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                    else               state_d = ST_HASH;
                end
                ST_HASH:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // The character is looked up for the *next* state so it can be registered.
    // Fields are only needed once past CARET, by which time they are latched.
    cpu_fmt_digit_sel #(
        .TIME_DIGITS (TIME_DIGITS)
    ) u_digit_sel (
        .state_i    (state_d),
        .cnt_i      (cnt_d),
        .kind_i     (kind_q),
        .time_bcd_i (time_q),
        .pc_i       (pc_q),
        .reg_num_i  (reg_q),
        .addr_i     (addr_q),
        .data_i     (data_q),
        .char_o     (sel_char)
    );

    assign req_ready_d = (state_d == ST_IDLE);
    assign out_valid_d = (state_d != ST_IDLE);
    assign out_char_d  = out_valid_d ? sel_char : 8'h00;
    assign err_d       = accept & bcd_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            kind_q      <= 1'b0;
            time_q      <= '0;
            pc_q        <= 32'd0;
            reg_q       <= 5'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            req_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            err_q       <= err_d;
            if (accept) begin
                kind_q <= req_kind;
                time_q <= time_bcd;
                pc_q   <= pc;
                reg_q  <= reg_num;
                addr_q <= addr;
                data_q <= data;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cpu_trace_formatter.sv
// -----------------------------------------------------------------------------
// tb_cpu_trace_formatter
// Directed bench for cpu_trace_formatter: reset values, register and memory
// lines, decimal register boundaries, malformed BCD, back-to-back requests,
// output backpressure and reset in the middle of a line. Expected strings
// follow CPU_FMT_LEAD_ZERO_TRIM_EN when it is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_trace_formatter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_kind;
    logic [15:0] time_bcd;
    logic [31:0] pc;
    logic [4:0]  reg_num;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    string EXP_REG;
    string EXP_MEM;
    int    DATA_IDX;
    int    PC3_IDX;

    always #5 clk = ~clk;

    cpu_trace_formatter #(.TIME_DIGITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .time_bcd  (time_bcd),
        .pc        (pc),
        .reg_num   (reg_num),
        .addr      (addr),
        .data      (data),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_req(input logic k, input logic [15:0] t, input logic [31:0] p,
                           input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        req_kind = k; time_bcd = t; pc = p; reg_num = r; addr = a; data = d;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_req(output bit ok);
        ok = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    // Collects characters with out_ready held high until '#' is taken.
    task automatic collect(output string s, output int cycles, output bit done);
        s = ""; cycles = 0; done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycles++;
            if (out_valid === 1'b1) begin
                s = $sformatf("%s%c", s, out_char);
                if (out_char === 8'h23) begin
                    @(posedge clk); #1;
                    done = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_line(output bit ok, output bit caret, output string s,
                           output int cycles, output bit done);
        send_req(ok);
        caret = (out_valid === 1'b1) && (out_char === 8'h5e);
        collect(s, cycles, done);
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
        set_req(1'b0, 16'h0, 32'h0, 5'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_char !== 8'h00) begin n_bad++; $display("FAIL reset_out_char: got %h want 00", out_char); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
        $display("reset: req_ready=%b out_valid=%b", req_ready, out_valid);
    endtask

    task automatic test_reg_line;
        bit ok, caret, done; string s; int cyc;
        set_req(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
        do_line(ok, caret, s, cyc, done);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL reg_accept: req_ready never seen"); end
        n_cmp++; if (!caret) begin n_bad++; $display("FAIL reg_caret_latency: got valid=%b char=%h want 1/5e", out_valid, out_char); end
        n_cmp++; if (s != EXP_REG) begin n_bad++; $display("FAIL reg_line: got \"%s\" want \"%s\"", s, EXP_REG); end
        n_cmp++; if (cyc != EXP_REG.len() || !done) begin n_bad++; $display("FAIL reg_beats: got %0d cycles done=%b want %0d", cyc, done, EXP_REG.len()); end
        n_cmp++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL reg_end_bubble: got ready=%b valid=%b want 1/0", req_ready, out_valid); end
        $display("reg line: \"%s\" beats=%0d", s, cyc);
    endtask

    task automatic test_mem_line;
        bit ok, caret, done; string s; int cyc;
        set_req(1'b1, 16'h0000, 32'h00003004, 5'd0, 32'h00001000, 32'h12345678);
        do_line(ok, caret, s, cyc, done);
        n_cmp++; if (!ok || !caret) begin n_bad++; $display("FAIL mem_start: got ok=%b caret=%b want 1/1", ok, caret); end
        n_cmp++; if (s != EXP_MEM) begin n_bad++; $display("FAIL mem_line: got \"%s\" want \"%s\"", s, EXP_MEM); end
        n_cmp++; if (cyc != EXP_MEM.len() || !done) begin n_bad++; $display("FAIL mem_beats: got %0d cycles want %0d", cyc, EXP_MEM.len()); end
        $display("mem line: \"%s\" beats=%0d", s, cyc);
    endtask

    task automatic test_decimal;
        bit ok, caret, done; string s; int cyc;
        logic [15:0] tv[3];
        logic [31:0] pv[3];
        logic [4:0]  rv[3];
        logic [31:0] dv[3];
        string       ev[3];
        tv = '{16'h0900, 16'h1000, 16'h0001};
        pv = '{32'hdeadbeef, 32'h00000000, 32'h89abcdef};
        rv = '{5'd31, 5'd10, 5'd0};
        dv = '{32'hffffffff, 32'h0a0b0c0d, 32'h76543210};
`ifdef CPU_FMT_LEAD_ZERO_TRIM_EN
        ev = '{"^900@deadbeef: $31 <= ffffffff#",
               "^1000@00000000: $10 <= 0a0b0c0d#",
               "^1@89abcdef: $0 <= 76543210#"};
`else
        ev = '{"^0900@deadbeef: $31 <= ffffffff#",
               "^1000@00000000: $10 <= 0a0b0c0d#",
               "^0001@89abcdef: $00 <= 76543210#"};
`endif
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, tv[i], pv[i], rv[i], 32'h0, dv[i]);
            do_line(ok, caret, s, cyc, done);
            n_cmp++; if (s != ev[i] || !done) begin n_bad++; $display("FAIL decimal_%0d: got \"%s\" want \"%s\"", i, s, ev[i]); end
            $display("decimal %0d: \"%s\"", i, s);
        end
    endtask

    task automatic test_bad_bcd;
        bit ok, caret, done; string s; int cyc;
        set_req(1'b0, 16'h00a1, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
        send_req(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bcd_accept: req_ready never seen"); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bcd_err_pulse: got %b want 1", err); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bcd_no_output: got valid=%b want 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bcd_err_width: got %b want 0", err); end
        n_cmp++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL bcd_idle: got valid=%b ready=%b want 0/1", out_valid, req_ready); end
        set_req(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
        do_line(ok, caret, s, cyc, done);
        n_cmp++; if (s != EXP_REG) begin n_bad++; $display("FAIL bcd_recover: got \"%s\" want \"%s\"", s, EXP_REG); end
        $display("bad bcd: err pulse seen, next line \"%s\"", s);
    endtask

    task automatic test_back_to_back;
        bit ok, caret, done; string s; int cyc;
        set_req(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
        send_req(ok);
        // Second request is offered (with new fields) while the first is busy.
        set_req(1'b1, 16'h0000, 32'h00003004, 5'd0, 32'h00001000, 32'h12345678);
        req_valid = 1'b1;
        collect(s, cyc, done);
        n_cmp++; if (s != EXP_REG) begin n_bad++; $display("FAIL b2b_first: got \"%s\" want \"%s\"", s, EXP_REG); end
        n_cmp++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_bubble: got valid=%b ready=%b want 0/1", out_valid, req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_char !== 8'h5e) begin n_bad++; $display("FAIL b2b_caret: got valid=%b char=%h want 1/5e", out_valid, out_char); end
        collect(s, cyc, done);
        n_cmp++; if (s != EXP_MEM) begin n_bad++; $display("FAIL b2b_second: got \"%s\" want \"%s\"", s, EXP_MEM); end
        $display("back to back: second \"%s\"", s);
    endtask

    task automatic test_backpressure;
        bit ok, stalled_prev, done; string s; int c, hold; logic [7:0] prev_char;
        set_req(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
        send_req(ok);
        s = ""; c = 0; hold = 0; stalled_prev = 1'b0; prev_char = 8'h00; done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (s.len() == DATA_IDX + 2 && hold < 5) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = (c % 2 == 0);
                c++;
            end
            if (stalled_prev) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_char !== prev_char) begin
                    n_bad++;
                    $display("FAIL bp_stable: got valid=%b char=%h want 1/%h", out_valid, out_char, prev_char);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                s = $sformatf("%s%c", s, out_char);
                if (out_char === 8'h23) begin
                    @(posedge clk); #1;
                    done = 1'b1;
                    break;
                end
            end
            stalled_prev = (out_valid === 1'b1) && !out_ready;
            prev_char = out_char;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n_cmp++; if (s != EXP_REG || !done) begin n_bad++; $display("FAIL bp_line: got \"%s\" want \"%s\"", s, EXP_REG); end
        n_cmp++; if (hold != 5) begin n_bad++; $display("FAIL bp_data_hold: got %0d stall cycles want 5", hold); end
        $display("backpressure: \"%s\"", s);
    endtask

    task automatic test_reset_midline;
        bit ok, caret, done; string s; int cyc;
        set_req(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
        send_req(ok);
        out_ready = 1'b1;
        s = "";
        for (int i = 0; i < 50; i++) begin
            if (s.len() == PC3_IDX) break;
            if (out_valid === 1'b1) s = $sformatf("%s%c", s, out_char);
            @(posedge clk); #1;
        end
        n_cmp++; if (out_valid !== 1'b1 || out_char !== 8'h33) begin n_bad++; $display("FAIL mid_pc3: got valid=%b char=%h want 1/33", out_valid, out_char); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || out_char !== 8'h00 || req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_abort: got valid=%b char=%h ready=%b want 0/00/0", out_valid, out_char, req_ready); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got ready=%b valid=%b want 1/0", req_ready, out_valid); end
        $display("reset mid-line: aborted after \"%s\"", s);
        do_line(ok, caret, s, cyc, done);
        n_cmp++; if (!caret || s != EXP_REG) begin n_bad++; $display("FAIL mid_new_line: got \"%s\" want \"%s\"", s, EXP_REG); end
        $display("reset mid-line: new line \"%s\"", s);
    endtask

    initial begin
`ifdef CPU_FMT_LEAD_ZERO_TRIM_EN
        EXP_REG  = "^12@00003000: $5 <= 0000abcd#";
        EXP_MEM  = "^0@00003004: *00001000 <= 12345678#";
        DATA_IDX = 20;
        PC3_IDX  = 8;
`else
        EXP_REG  = "^0012@00003000: $05 <= 0000abcd#";
        EXP_MEM  = "^0000@00003004: *00001000 <= 12345678#";
        DATA_IDX = 23;
        PC3_IDX  = 10;
`endif
        test_reset();
        test_reg_line();
        test_mem_line();
        test_decimal();
        test_bad_bcd();
        test_back_to_back();
        test_backpressure();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
